// File: rtl/tpu_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array job sequencer.
package tpu_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_LOAD,
    CTRL_STREAM,
    CTRL_DRAIN
  } ctrl_state_t;

  // Cycles between the last west-edge valid and the last south-edge valid.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

  // Job cycle counter width; wide enough for the longest job without wrapping.
  function automatic int unsigned cycle_cnt_w(input int unsigned rows, input int unsigned cols,
                                              input int unsigned len_w);
    return len_w + $clog2(2 * rows + cols + 2);
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Control bus between a job issuer (master) and the systolic array sequencer (slave).
interface systolic_ctrl_if #(
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned AW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
);

  logic                 start;
  logic [LEN_W-1:0]     num_vectors;
  logic                 busy;
  logic                 done;
  logic                 wbuf_rd_en;
  logic [AW_W-1:0]      wbuf_rd_addr;
  logic                 ibuf_rd_en;
  logic [LEN_W-1:0]     ibuf_rd_addr;
  logic                 array_en;
  logic [ROWS-1:0]      row_accept_w;
  logic [ROWS-1:0]      row_switch;
  logic [ROWS-1:0]      row_valid;
  logic [COLS-1:0]      col_out_valid;

  modport master (
    output start, num_vectors,
    input  busy, done, wbuf_rd_en, wbuf_rd_addr, ibuf_rd_en, ibuf_rd_addr,
    input  array_en, row_accept_w, row_switch, row_valid, col_out_valid
  );

  modport slave (
    input  start, num_vectors,
    output busy, done, wbuf_rd_en, wbuf_rd_addr, ibuf_rd_en, ibuf_rd_addr,
    output array_en, row_accept_w, row_switch, row_valid, col_out_valid
  );

endinterface

// File: rtl/ctrl_skew_line.sv
// Synchronous-reset shift register; tap i presents the input delayed by i+1 cycles.
module ctrl_skew_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             d_i,
  output logic [DEPTH-1:0][WIDTH-1:0]  tap_o
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tap_o = pipe_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for a weight-stationary ROWS x COLS systolic array.
// Optional SYSTOLIC_CTRL_PERF_CNT_EN adds busy-cycle and job performance counters.
module systolic_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned AW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  output logic [31:0]          perf_busy_cycles,
  output logic [15:0]          perf_jobs,
`endif
  systolic_ctrl_if.slave       bus
);

  localparam int unsigned CNT_W = cycle_cnt_w(ROWS, COLS, LEN_W);
  localparam int unsigned DRAIN = drain_len(ROWS, COLS);

  ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  num_q, num_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wbuf_en_q, wbuf_en_d;
  logic [AW_W-1:0]   wbuf_addr_q, wbuf_addr_d;
  logic              ibuf_en_q, ibuf_en_d;
  logic [LEN_W-1:0]  ibuf_addr_q, ibuf_addr_d;
  logic              accept_q, accept_d;
  logic              valid0_q, valid0_d;
  logic              switch0_q, switch0_d;
  logic              col0_q, col0_d;

  logic [CNT_W-1:0]  last_load, last_stream, last_drain;
  logic [CNT_W-1:0]  stream_end_d;

  // Job phase boundaries in cycle-counter units, for the job in flight.
  assign last_load   = CNT_W'(ROWS);
  assign last_stream = CNT_W'(ROWS) + CNT_W'(num_q);
  assign last_drain  = last_stream + CNT_W'(DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CTRL_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wbuf_en_q   <= 1'b0;
      wbuf_addr_q <= '0;
      ibuf_en_q   <= 1'b0;
      ibuf_addr_q <= '0;
      accept_q    <= 1'b0;
      valid0_q    <= 1'b0;
      switch0_q   <= 1'b0;
      col0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wbuf_en_q   <= wbuf_en_d;
      wbuf_addr_q <= wbuf_addr_d;
      ibuf_en_q   <= ibuf_en_d;
      ibuf_addr_q <= ibuf_addr_d;
      accept_q    <= accept_d;
      valid0_q    <= valid0_d;
      switch0_q   <= switch0_d;
      col0_q      <= col0_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    num_d        = num_q;
    done_d       = 1'b0;
    busy_d       = 1'b0;
    wbuf_en_d    = 1'b0;
    wbuf_addr_d  = '0;
    ibuf_en_d    = 1'b0;
    ibuf_addr_d  = '0;
    accept_d     = 1'b0;
    valid0_d     = 1'b0;
    switch0_d    = 1'b0;
    col0_d       = 1'b0;
    stream_end_d = '0;

    case (state_q)
      CTRL_IDLE: begin
        if (bus.start) begin
          if (bus.num_vectors != '0) begin
            state_d = CTRL_LOAD;
            cnt_d   = '0;
            num_d   = bus.num_vectors;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      CTRL_LOAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_load) state_d = CTRL_STREAM;
      end
      CTRL_STREAM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_stream) state_d = CTRL_DRAIN;
      end
      CTRL_DRAIN: begin
        if (cnt_q == last_drain) begin
          state_d = CTRL_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = CTRL_IDLE;
    endcase

    // Output values for the upcoming cycle, decoded from its state and count.
    stream_end_d = CNT_W'(ROWS) + CNT_W'(num_d);
    busy_d       = (state_d != CTRL_IDLE);
    wbuf_en_d    = (state_d == CTRL_LOAD) && (cnt_d < CNT_W'(ROWS));
    accept_d     = (state_d == CTRL_LOAD) && (cnt_d != '0);
    ibuf_en_d    = busy_d && (cnt_d >= CNT_W'(ROWS)) && (cnt_d < stream_end_d);
    valid0_d     = (state_d == CTRL_STREAM);
    switch0_d    = (state_d == CTRL_STREAM) && (cnt_d == CNT_W'(ROWS + 1));
    col0_d       = busy_d && (cnt_d >= CNT_W'(2 * ROWS + 1))
                          && (cnt_d <= stream_end_d + CNT_W'(ROWS));
    if (wbuf_en_d) wbuf_addr_d = AW_W'(CNT_W'(ROWS - 1) - cnt_d);
    if (ibuf_en_d) ibuf_addr_d = LEN_W'(cnt_d - CNT_W'(ROWS));
  end

  logic [ROWS-1:0] row_valid_w;
  logic [ROWS-1:0] row_switch_w;
  logic [COLS-1:0] col_valid_w;

  assign row_valid_w[0]  = valid0_q;
  assign row_switch_w[0] = switch0_q;
  assign col_valid_w[0]  = col0_q;

  // Row r of the west edge sees row 0's control bits r cycles later.
  if (ROWS > 1) begin : g_row_skew
    logic [ROWS-2:0][1:0] row_taps;

    ctrl_skew_line #(
      .WIDTH (2),
      .DEPTH (ROWS - 1)
    ) u_row_skew (
      .clk   (clk),
      .rst   (rst),
      .d_i   ({switch0_q, valid0_q}),
      .tap_o (row_taps)
    );

    for (genvar r = 1; r < int'(ROWS); r++) begin : g_row_tap
      assign row_valid_w[r]  = row_taps[r-1][0];
      assign row_switch_w[r] = row_taps[r-1][1];
    end
  end

  if (COLS > 1) begin : g_col_skew
    logic [COLS-2:0][0:0] col_taps;

    ctrl_skew_line #(
      .WIDTH (1),
      .DEPTH (COLS - 1)
    ) u_col_skew (
      .clk   (clk),
      .rst   (rst),
      .d_i   (col0_q),
      .tap_o (col_taps)
    );

    for (genvar c = 1; c < int'(COLS); c++) begin : g_col_tap
      assign col_valid_w[c] = col_taps[c-1][0];
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.array_en      = busy_q;
  assign bus.wbuf_rd_en    = wbuf_en_q;
  assign bus.wbuf_rd_addr  = wbuf_addr_q;
  assign bus.ibuf_rd_en    = ibuf_en_q;
  assign bus.ibuf_rd_addr  = ibuf_addr_q;
  assign bus.row_accept_w  = {ROWS{accept_q}};
  assign bus.row_valid     = row_valid_w;
  assign bus.row_switch    = row_switch_w;
  assign bus.col_out_valid = col_valid_w;

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0] perf_busy_q;
  logic [15:0] perf_jobs_q;

  // Saturating counters; they see the registered busy/done of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_q <= '0;
      perf_jobs_q <= '0;
    end else begin
      if (busy_q && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
      if (done_q && (perf_jobs_q != '1)) perf_jobs_q <= perf_jobs_q + 16'd1;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_jobs        = perf_jobs_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl (2x2 and 4x3 instances) against a timeline reference model.
module tb_systolic_ctrl;

  localparam int unsigned LEN_W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.ROWS(2), .COLS(2), .LEN_W(LEN_W)) bus0 ();
  systolic_ctrl_if #(.ROWS(4), .COLS(3), .LEN_W(LEN_W)) bus1 ();

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0] pbc0, pbc1;
  logic [15:0] pj0, pj1;
`endif

  systolic_ctrl #(.ROWS(2), .COLS(2), .LEN_W(LEN_W)) u_dut0 (
    .clk              (clk),
    .rst              (rst),
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    .perf_busy_cycles (pbc0),
    .perf_jobs        (pj0),
`endif
    .bus              (bus0)
  );

  systolic_ctrl #(.ROWS(4), .COLS(3), .LEN_W(LEN_W)) u_dut1 (
    .clk              (clk),
    .rst              (rst),
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    .perf_busy_cycles (pbc1),
    .perf_jobs        (pj1),
`endif
    .bus              (bus1)
  );

  typedef struct {
    logic       busy;
    logic       ae;
    logic       done;
    logic       wb_en;
    int         wb_addr;
    logic       ib_en;
    int         ib_addr;
    logic [7:0] acc;
    logic [7:0] sw;
    logic [7:0] vld;
    logic [7:0] col;
  } exp_t;

  int n_checks;
  int n_errors;
  int cyc;

  // Reference model: per instance, the accepted job start cycle and length.
  int rows_c [2] = '{2, 4};
  int cols_c [2] = '{2, 3};
  int t0 [2];
  int jn [2];
  int zd [2];
  bit on [2];
  int perf_busy_m [2];
  int perf_jobs_m [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t model_at(input int d, input int c);
    exp_t e;
    int   k, rr, cc, n, t;
    rr = rows_c[d];
    cc = cols_c[d];
    n  = jn[d];
    k  = c - t0[d];
    t  = 2 * rr + cc + n;
    e.busy = 1'b0; e.ae = 1'b0; e.wb_en = 1'b0; e.wb_addr = 0;
    e.ib_en = 1'b0; e.ib_addr = 0;
    e.acc = '0; e.sw = '0; e.vld = '0; e.col = '0;
    e.done = (zd[d] == c) || (on[d] && k == t);
    if (on[d] && k >= 0 && k < t) begin
      e.busy    = 1'b1;
      e.ae      = 1'b1;
      e.wb_en   = (k < rr);
      e.wb_addr = rr - 1 - k;
      e.ib_en   = (k >= rr) && (k < rr + n);
      e.ib_addr = k - rr;
      for (int r = 0; r < rr; r++) begin
        e.acc[r] = (k >= 1) && (k <= rr);
        e.vld[r] = (k >= rr + 1 + r) && (k <= rr + n + r);
        e.sw[r]  = (k == rr + 1 + r);
      end
      for (int c2 = 0; c2 < cc; c2++) begin
        e.col[c2] = (k >= 2 * rr + 1 + c2) && (k <= 2 * rr + c2 + n);
      end
    end
    return e;
  endfunction

  task automatic model_update(input int d, input bit r, input bit s, input int n);
    exp_t pe;
    if (r) begin
      on[d] = 1'b0;
      zd[d] = -1;
      perf_busy_m[d] = 0;
      perf_jobs_m[d] = 0;
      return;
    end
    pe = model_at(d, cyc - 1);
    perf_busy_m[d] += int'(pe.busy);
    perf_jobs_m[d] += int'(pe.done);
    if (!pe.busy && s) begin
      if (n != 0) begin
        on[d] = 1'b1;
        t0[d] = cyc;
        jn[d] = n;
      end else begin
        zd[d] = cyc;
      end
    end
  endtask

  task automatic check_dut(input int d);
    exp_t  e, o;
    string p;
    e = model_at(d, cyc);
    p = (d == 0) ? "d0" : "d1";
    if (d == 0) begin
      o.busy = bus0.busy; o.ae = bus0.array_en; o.done = bus0.done;
      o.wb_en = bus0.wbuf_rd_en; o.wb_addr = int'(bus0.wbuf_rd_addr);
      o.ib_en = bus0.ibuf_rd_en; o.ib_addr = int'(bus0.ibuf_rd_addr);
      o.acc = 8'(bus0.row_accept_w); o.sw = 8'(bus0.row_switch);
      o.vld = 8'(bus0.row_valid); o.col = 8'(bus0.col_out_valid);
    end else begin
      o.busy = bus1.busy; o.ae = bus1.array_en; o.done = bus1.done;
      o.wb_en = bus1.wbuf_rd_en; o.wb_addr = int'(bus1.wbuf_rd_addr);
      o.ib_en = bus1.ibuf_rd_en; o.ib_addr = int'(bus1.ibuf_rd_addr);
      o.acc = 8'(bus1.row_accept_w); o.sw = 8'(bus1.row_switch);
      o.vld = 8'(bus1.row_valid); o.col = 8'(bus1.col_out_valid);
    end
    check({p, ".busy"},       32'(o.busy),  32'(e.busy));
    check({p, ".array_en"},   32'(o.ae),    32'(e.ae));
    check({p, ".done"},       32'(o.done),  32'(e.done));
    check({p, ".wbuf_rd_en"}, 32'(o.wb_en), 32'(e.wb_en));
    if (e.wb_en) check({p, ".wbuf_rd_addr"}, 32'(o.wb_addr), 32'(e.wb_addr));
    check({p, ".ibuf_rd_en"}, 32'(o.ib_en), 32'(e.ib_en));
    if (e.ib_en) check({p, ".ibuf_rd_addr"}, 32'(o.ib_addr), 32'(e.ib_addr));
    check({p, ".row_accept_w"},  32'(o.acc), 32'(e.acc));
    check({p, ".row_switch"},    32'(o.sw),  32'(e.sw));
    check({p, ".row_valid"},     32'(o.vld), 32'(e.vld));
    check({p, ".col_out_valid"}, 32'(o.col), 32'(e.col));
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check({p, ".perf_busy_cycles"}, (d == 0) ? pbc0 : pbc1, 32'(perf_busy_m[d]));
    check({p, ".perf_jobs"},        32'((d == 0) ? pj0 : pj1), 32'(perf_jobs_m[d]));
`endif
  endtask

  // Drive one cycle of inputs, take the edge, advance the model, then compare.
  task automatic step(input bit r, input bit s0, input int n0, input bit s1, input int n1);
    rst              = r;
    bus0.start       = s0;
    bus0.num_vectors = LEN_W'(n0);
    bus1.start       = s1;
    bus1.num_vectors = LEN_W'(n1);
    @(posedge clk);
    cyc++;
    model_update(0, r, s0, n0);
    model_update(1, r, s1, n1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  function automatic int pick_len();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) return 0;
    if (sel == 1) return int'($urandom_range(0, 255));
    return int'($urandom_range(1, 8));
  endfunction

  initial begin
    int last_addr, col2_cnt, done_k;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    for (int d = 0; d < 2; d++) begin
      on[d] = 1'b0; zd[d] = -1; t0[d] = 0; jn[d] = 0;
      perf_busy_m[d] = 0; perf_jobs_m[d] = 0;
    end

    repeat (3) step(1'b1, 1'b0, 0, 1'b0, 0);
    check("rst.wbuf_rd_addr", 32'(bus0.wbuf_rd_addr), 32'd0);
    check("rst.ibuf_rd_addr", 32'(bus0.ibuf_rd_addr), 32'd0);
    step(1'b0, 1'b0, 0, 1'b0, 0);

    // 2x2, N=3: done lands in job cycle 9.
    step(1'b0, 1'b1, 3, 1'b0, 0);
    check("t1.wbuf_addr_c0", 32'(bus0.wbuf_rd_addr), 32'd1);
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b0, 0, 1'b0, 0);
    check("t1.done_c9", 32'(bus0.done), 32'd1);

    // Zero-length job started in the done cycle: done next cycle, never busy.
    step(1'b0, 1'b1, 0, 1'b0, 0);
    check("t2.done", 32'(bus0.done), 32'd1);
    check("t2.busy", 32'(bus0.busy), 32'd0);
    step(1'b0, 1'b0, 0, 1'b0, 0);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check("t2.perf_jobs", 32'(pj0), 32'd2);
    check("t2.perf_busy_cycles", pbc0, 32'd9);
`endif

    // Start during cycle 4 ignored; start during done cycle 9 is accepted.
    step(1'b0, 1'b1, 3, 1'b0, 0);
    for (int i = 1; i <= 9; i++) step(1'b0, (i == 5), 7, 1'b0, 0);
    step(1'b0, 1'b1, 3, 1'b0, 0);
    check("t3.restart_wbuf_en", 32'(bus0.wbuf_rd_en), 32'd1);
    check("t3.restart_wbuf_addr", 32'(bus0.wbuf_rd_addr), 32'd1);

    // Reset in cycle 4 of that job abandons it; then a clean job.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 1'b0, 0);
    check("t4.busy_after_rst", 32'(bus0.busy), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 3, 1'b0, 0);
    for (int i = 1; i <= 11; i++) step(1'b0, 1'b0, 0, 1'b0, 0);

    // 4x3, N=255: longest job.
    last_addr = -1;
    col2_cnt  = 0;
    done_k    = -1;
    step(1'b0, 1'b0, 0, 1'b1, 255);
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 1'b0, 0, 1'b0, 0);
      if (bus1.ibuf_rd_en) last_addr = int'(bus1.ibuf_rd_addr);
      if (bus1.col_out_valid[2]) col2_cnt++;
      if (bus1.done) begin
        done_k = k;
        break;
      end
    end
    check("t5.last_ibuf_addr", 32'(last_addr), 32'd254);
    check("t5.col2_cycles", 32'(col2_cnt), 32'd255);
    check("t5.done_cycle", 32'(done_k), 32'd266);

    // Random traffic on both instances, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 5) == 0), pick_len(),
           ($urandom_range(0, 5) == 0), pick_len());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
